// File: rtl/oq_regs_rmw_ram_if.sv
// Host (A) and datapath read-modify-write (B) ports of the output-queue register RAM.
// The master drives the requests and the slave returns acks and responses.
`timescale 1ns/1ps
interface oq_regs_rmw_ram_if #(
    parameter int REG_WIDTH  = 32,
    parameter int ADDR_WIDTH = 3
);
    logic                  a_req;
    logic                  a_rd_wr_L;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [REG_WIDTH-1:0]  a_wr_data;
    logic                  a_ack;
    logic [REG_WIDTH-1:0]  a_rd_data;

    logic                  b_valid;
    logic                  b_ready;
    logic [1:0]            b_op;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [REG_WIDTH-1:0]  b_data;
    logic                  b_rsp_valid;
    logic [REG_WIDTH-1:0]  b_old;
    logic [REG_WIDTH-1:0]  b_new;
    logic                  b_clamp;

    modport master (
        output a_req, a_rd_wr_L, a_addr, a_wr_data, b_valid, b_op, b_addr, b_data,
        input  a_ack, a_rd_data, b_ready, b_rsp_valid, b_old, b_new, b_clamp
    );

    modport slave (
        input  a_req, a_rd_wr_L, a_addr, a_wr_data, b_valid, b_op, b_addr, b_data,
        output a_ack, a_rd_data, b_ready, b_rsp_valid, b_old, b_new, b_clamp
    );
endinterface

// File: rtl/oq_regs_rmw_ram.sv
// Per-queue register RAM: host R/W port A, datapath read/write/add/sub port B, clear sweep after reset.
// Latency 2 cycles on both ports; no backpressure once init_done, requests ignored during the sweep.
`timescale 1ns/1ps
module oq_regs_rmw_ram #(
    parameter int                    REG_WIDTH           = 32,
    parameter int                    NUM_OUTPUT_QUEUES   = 8,
    parameter int                    REG_FILE_ADDR_WIDTH = (NUM_OUTPUT_QUEUES > 1) ? $clog2(NUM_OUTPUT_QUEUES) : 1,
    parameter logic [REG_WIDTH-1:0]  INIT_VALUE          = '0,
    parameter bit                    SATURATE            = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    output logic                   init_done,
    oq_regs_rmw_ram_if.slave       rf
);
    localparam int W  = REG_WIDTH;
    localparam int AW = REG_FILE_ADDR_WIDTH;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] SWEEP_END = CW'(NUM_OUTPUT_QUEUES);
    localparam logic [1:0] OP_RD = 2'b00, OP_WR = 2'b01, OP_ADD = 2'b10, OP_SUB = 2'b11;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   sweep_cnt;
    logic            sweep_we, run;
    logic            a_acc, a_in, a_we, b_acc, b_in;

    logic [W-1:0]    mem [NUM_OUTPUT_QUEUES];
    logic [W-1:0]    dout_a, dout_b;
    logic            w0_en;
    logic [AW-1:0]   w0_addr;
    logic [W-1:0]    w0_dat;

    logic            s1_vld, s1_in;
    logic [1:0]      s1_op;
    logic [AW-1:0]   s1_addr;
    logic [W-1:0]    s1_dat;
    logic            a1_vld, a1_rd, a1_in;
    logic [AW-1:0]   a1_addr;

    logic            wb_vld, afw_vld;
    logic [AW-1:0]   wb_addr, afw_addr;
    logic [W-1:0]    wb_dat, afw_dat;

    logic [W-1:0]    b_old_c, b_new_c, a_rd_c;
    logic [W:0]      sum_c, dif_c;
    logic            b_clamp_c, b_we;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_INIT;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && sweep_cnt == SWEEP_END) state_nxt = ST_RUN;
    end

    always_comb begin
        run      = (state == ST_RUN);
        sweep_we = (state == ST_INIT) && (sweep_cnt != SWEEP_END);
    end

    assign init_done  = run;
    assign rf.b_ready = run;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      sweep_cnt <= '0;
        else if (sweep_we) sweep_cnt <= sweep_cnt + CW'(1);
    end

    assign a_acc = run && rf.a_req;
    assign a_in  = {1'b0, rf.a_addr} < SWEEP_END;
    assign a_we  = a_acc && !rf.a_rd_wr_L && a_in;
    assign b_acc = run && rf.b_valid;
    assign b_in  = {1'b0, rf.b_addr} < SWEEP_END;

    // S2: newest committed value wins over the RAM read that raced it at the last edge.
    always_comb begin
        b_old_c = dout_b;
        if (!s1_in)                                b_old_c = '0;
        else if (wb_vld && wb_addr == s1_addr)     b_old_c = wb_dat;
        else if (afw_vld && afw_addr == s1_addr)   b_old_c = afw_dat;
        sum_c     = {1'b0, b_old_c} + {1'b0, s1_dat};
        dif_c     = {1'b0, b_old_c} - {1'b0, s1_dat};
        b_new_c   = b_old_c;
        b_clamp_c = 1'b0;
        case (s1_op)
            OP_WR:  b_new_c = s1_dat;
            OP_ADD: begin
                b_clamp_c = sum_c[W];
                b_new_c   = (sum_c[W] && SATURATE) ? '1 : sum_c[W-1:0];
            end
            OP_SUB: begin
                b_clamp_c = dif_c[W];
                b_new_c   = (dif_c[W] && SATURATE) ? '0 : dif_c[W-1:0];
            end
            default: ;
        endcase
        // A host write landing on the same word in the same cycle takes precedence.
        b_we    = s1_vld && s1_in && (s1_op != OP_RD) && !(a_we && rf.a_addr == s1_addr);
        a_rd_c  = '0;
        if (a1_rd && a1_in) a_rd_c = (wb_vld && wb_addr == a1_addr) ? wb_dat : dout_a;
        w0_en   = sweep_we || b_we;
        w0_addr = sweep_we ? sweep_cnt[AW-1:0] : s1_addr;
        w0_dat  = sweep_we ? INIT_VALUE : b_new_c;
    end

    always_ff @(posedge clk) begin
        if (w0_en) mem[w0_addr]   <= w0_dat;
        if (a_we)  mem[rf.a_addr] <= rf.a_wr_data;
        dout_a <= mem[rf.a_addr];
        dout_b <= mem[rf.b_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld <= 1'b0; s1_in <= 1'b0; s1_op <= '0; s1_addr <= '0; s1_dat <= '0;
            a1_vld <= 1'b0; a1_rd <= 1'b0; a1_in <= 1'b0; a1_addr <= '0;
            wb_vld <= 1'b0; wb_addr <= '0; wb_dat <= '0;
            afw_vld <= 1'b0; afw_addr <= '0; afw_dat <= '0;
            rf.b_rsp_valid <= 1'b0; rf.b_old <= '0; rf.b_new <= '0; rf.b_clamp <= 1'b0;
            rf.a_ack <= 1'b0; rf.a_rd_data <= '0;
        end else begin
            s1_vld <= b_acc;
            if (b_acc) begin
                s1_in <= b_in; s1_op <= rf.b_op; s1_addr <= rf.b_addr; s1_dat <= rf.b_data;
            end
            a1_vld <= a_acc;
            if (a_acc) begin
                a1_rd <= rf.a_rd_wr_L; a1_in <= a_in; a1_addr <= rf.a_addr;
            end
            wb_vld   <= b_we;
            wb_addr  <= s1_addr;
            wb_dat   <= b_new_c;
            afw_vld  <= a_we;
            afw_addr <= rf.a_addr;
            afw_dat  <= rf.a_wr_data;
            rf.b_rsp_valid <= s1_vld;
            if (s1_vld) begin
                rf.b_old <= b_old_c; rf.b_new <= b_new_c; rf.b_clamp <= b_clamp_c;
            end
            rf.a_ack <= a1_vld;
            if (a1_vld) rf.a_rd_data <= a_rd_c;
        end
    end
endmodule

// File: tb/tb_oq_regs_rmw_ram.sv
// Scoreboard bench: dut0 (8 words, INIT 5, saturating) against a behavioural model,
// dut1 (6 words, INIT 0, wrapping) with directed single-op checks.
`timescale 1ns/1ps
module tb_oq_regs_rmw_ram;
    localparam int N0 = 8;
    localparam int N1 = 6;
    localparam int AW = 3;
    localparam logic [31:0] IV0 = 32'd5;
    localparam logic [1:0] RD = 2'b00, WR = 2'b01, ADD = 2'b10, SUB = 2'b11;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic init_done0, init_done1;
    always #5 clk = ~clk;

    oq_regs_rmw_ram_if #(.REG_WIDTH(32), .ADDR_WIDTH(AW)) if0 ();
    oq_regs_rmw_ram_if #(.REG_WIDTH(32), .ADDR_WIDTH(AW)) if1 ();

    oq_regs_rmw_ram #(.REG_WIDTH(32), .NUM_OUTPUT_QUEUES(N0), .REG_FILE_ADDR_WIDTH(AW),
                      .INIT_VALUE(IV0), .SATURATE(1'b1))
        dut0 (.clk(clk), .reset_n(reset_n), .init_done(init_done0), .rf(if0.slave));
    oq_regs_rmw_ram #(.REG_WIDTH(32), .NUM_OUTPUT_QUEUES(N1), .REG_FILE_ADDR_WIDTH(AW),
                      .INIT_VALUE(32'd0), .SATURATE(1'b0))
        dut1 (.clk(clk), .reset_n(reset_n), .init_done(init_done1), .rf(if1.slave));

    typedef struct { int due; logic [31:0] old_v; logic [31:0] new_v; logic clamp; } bexp_t;
    typedef struct { int due; logic [31:0] dat; } aexp_t;
    bexp_t bq[$];
    aexp_t aq[$];

    int n_vec = 0, n_err = 0;
    int edge_no = 0, since_rst = 0;
    logic [31:0] mdl [N0];
    bit pend_vld = 1'b0;
    int pend_addr = 0;
    logic [31:0] pend_val = '0;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] calc(logic [1:0] op, logic [31:0] old, logic [31:0] d);
        logic [32:0] s;
        calc = {1'b0, old};
        case (op)
            WR:  calc = {1'b0, d};
            ADD: begin s = {1'b0, old} + {1'b0, d}; calc = s[32] ? {1'b1, 32'hFFFF_FFFF} : s; end
            SUB: begin s = {1'b0, old} - {1'b0, d}; calc = s[32] ? {1'b1, 32'h0} : s; end
            default: ;
        endcase
    endfunction

    // Sequential semantics per cycle: previous B write, then this cycle's A access, then this B op.
    task automatic model_step();
        logic [32:0] r;
        logic [31:0] old;
        if (pend_vld) mdl[pend_addr] = pend_val;
        pend_vld = 1'b0;
        if (since_rst >= N0 + 1) begin
            if (if0.a_req) begin
                if (!if0.a_rd_wr_L) begin
                    mdl[if0.a_addr] = if0.a_wr_data;
                    aq.push_back('{edge_no + 2, 32'h0});
                end else aq.push_back('{edge_no + 2, mdl[if0.a_addr]});
            end
            if (if0.b_valid) begin
                old = mdl[if0.b_addr];
                r = calc(if0.b_op, old, if0.b_data);
                bq.push_back('{edge_no + 2, old, r[31:0], r[32]});
                if (if0.b_op != RD) begin
                    pend_vld = 1'b1; pend_addr = int'(if0.b_addr); pend_val = r[31:0];
                end
            end
        end
    endtask

    task automatic monitor();
        bexp_t be;
        aexp_t ae;
        if (if0.b_rsp_valid) begin
            if (bq.size() == 0) check("b_spurious_rsp", 1, 0);
            else begin
                be = bq.pop_front();
                check("b_latency", edge_no, be.due);
                check("b_old", if0.b_old, be.old_v);
                check("b_new", if0.b_new, be.new_v);
                check("b_clamp", if0.b_clamp, be.clamp);
            end
        end else if (bq.size() > 0 && bq[0].due <= edge_no) begin
            check("b_missing_rsp", 0, 1);
            void'(bq.pop_front());
        end
        if (if0.a_ack) begin
            if (aq.size() == 0) check("a_spurious_ack", 1, 0);
            else begin
                ae = aq.pop_front();
                check("a_latency", edge_no, ae.due);
                check("a_rd_data", if0.a_rd_data, ae.dat);
            end
        end else if (aq.size() > 0 && aq[0].due <= edge_no) begin
            check("a_missing_ack", 0, 1);
            void'(aq.pop_front());
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        edge_no++;
        if (!reset_n) since_rst = 0;
        else          since_rst++;
        monitor();
    endtask

    task automatic a_drv(bit rd, int addr, logic [31:0] d);
        if0.a_req = 1'b1; if0.a_rd_wr_L = rd; if0.a_addr = AW'(addr); if0.a_wr_data = d;
    endtask

    task automatic b_drv(logic [1:0] op, int addr, logic [31:0] d);
        if0.b_valid = 1'b1; if0.b_op = op; if0.b_addr = AW'(addr); if0.b_data = d;
    endtask

    task automatic idle0();
        if0.a_req = 1'b0; if0.b_valid = 1'b0;
    endtask

    task automatic check_zero_outputs(string tag);
        check({tag, "_init_done"}, init_done0, 0);
        check({tag, "_b_ready"}, if0.b_ready, 0);
        check({tag, "_b_rsp_valid"}, if0.b_rsp_valid, 0);
        check({tag, "_b_old"}, if0.b_old, 0);
        check({tag, "_b_new"}, if0.b_new, 0);
        check({tag, "_b_clamp"}, if0.b_clamp, 0);
        check({tag, "_a_ack"}, if0.a_ack, 0);
        check({tag, "_a_rd_data"}, if0.a_rd_data, 0);
    endtask

    task automatic release_and_sweep(string tag);
        reset_n = 1'b1;
        for (int i = 0; i < N0; i++) mdl[i] = IV0;
        for (int k = 1; k <= N0; k++) begin
            tick();
            check({tag, "_init_done_low"}, init_done0, 0);
        end
        tick();
        check({tag, "_init_done_high"}, init_done0, 1);
        check({tag, "_b_ready_high"}, if0.b_ready, 1);
        idle0();
        for (int i = 0; i < N0; i++) begin
            a_drv(1'b1, i, 32'h0);
            tick();
        end
        idle0();
        repeat (4) tick();
    endtask

    task automatic d1_b(logic [1:0] op, int addr, logic [31:0] d,
                        logic [31:0] e_old, logic [31:0] e_new, logic e_clamp, string tag);
        if1.b_valid = 1'b1; if1.b_op = op; if1.b_addr = AW'(addr); if1.b_data = d;
        tick();
        if1.b_valid = 1'b0;
        check({tag, "_early"}, if1.b_rsp_valid, 0);
        tick();
        check({tag, "_vld"}, if1.b_rsp_valid, 1);
        check({tag, "_old"}, if1.b_old, e_old);
        check({tag, "_new"}, if1.b_new, e_new);
        check({tag, "_clamp"}, if1.b_clamp, e_clamp);
    endtask

    task automatic d1_a(bit rd, int addr, logic [31:0] d, logic [31:0] e_rd, string tag);
        if1.a_req = 1'b1; if1.a_rd_wr_L = rd; if1.a_addr = AW'(addr); if1.a_wr_data = d;
        tick();
        if1.a_req = 1'b0;
        check({tag, "_early"}, if1.a_ack, 0);
        tick();
        check({tag, "_ack"}, if1.a_ack, 1);
        check({tag, "_rd"}, if1.a_rd_data, e_rd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle0();
        if0.a_rd_wr_L = 1'b1; if0.a_addr = '0; if0.a_wr_data = '0;
        if0.b_op = RD; if0.b_addr = '0; if0.b_data = '0;
        if1.a_req = 1'b0; if1.a_rd_wr_L = 1'b1; if1.a_addr = '0; if1.a_wr_data = '0;
        if1.b_valid = 1'b0; if1.b_op = RD; if1.b_addr = '0; if1.b_data = '0;

        repeat (3) tick();
        check_zero_outputs("rst");
        check("rst_init_done1", init_done1, 0);

        // Junk traffic held through the whole sweep must be ignored.
        a_drv(1'b0, 1, 32'hDEAD); b_drv(WR, 2, 32'hBEEF);
        release_and_sweep("init");
        check("init_done1", init_done1, 1);

        // Forwarding chain: host write and first add in the same cycle, then read right after.
        a_drv(1'b0, 3, 32'd10); b_drv(ADD, 3, 32'd1); tick();
        idle0();
        repeat (3) begin b_drv(ADD, 3, 32'd1); tick(); end
        idle0(); a_drv(1'b1, 3, 32'h0); tick();
        idle0(); repeat (4) tick();

        // Saturation corners.
        a_drv(1'b0, 0, 32'hFFFF_FFFE); tick();
        a_drv(1'b0, 1, 32'd1); b_drv(ADD, 0, 32'd5); tick();
        idle0(); b_drv(SUB, 1, 32'd3); tick();
        b_drv(ADD, 1, 32'd7); tick();
        b_drv(SUB, 0, 32'd1); tick();
        idle0(); repeat (4) tick();

        // Collision: host write lands in the cycle of the B write-back.
        b_drv(ADD, 2, 32'h10); tick();
        a_drv(1'b0, 2, 32'h100); b_drv(RD, 2, 32'h0); tick();
        idle0(); b_drv(RD, 2, 32'h0); tick();
        idle0(); a_drv(1'b1, 2, 32'h0); tick();
        idle0(); repeat (4) tick();

        // Wrapping instance and out-of-range addresses.
        d1_a(1'b0, 0, 32'hFFFF_FFFE, 32'h0, "d1_wr0");
        d1_b(ADD, 0, 32'd5, 32'hFFFF_FFFE, 32'd3, 1'b1, "d1_wrap_add");
        d1_b(SUB, 0, 32'd5, 32'd3, 32'hFFFF_FFFE, 1'b1, "d1_wrap_sub");
        d1_b(ADD, 0, 32'd1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, "d1_add");
        d1_a(1'b0, 6, 32'h77, 32'h0, "d1_oor_wr");
        d1_a(1'b1, 6, 32'h0, 32'h0, "d1_oor_rd");
        d1_b(ADD, 7, 32'd9, 32'd0, 32'd9, 1'b0, "d1_oor_add");
        d1_b(RD, 7, 32'h0, 32'd0, 32'd0, 1'b0, "d1_oor_rdb");
        d1_b(WR, 5, 32'h42, 32'd0, 32'h42, 1'b0, "d1_last_wr");
        d1_a(1'b1, 5, 32'h0, 32'h42, "d1_last_rd");
        d1_a(1'b1, 0, 32'h0, 32'hFFFF_FFFF, "d1_rd0");

        // Mixed random traffic on both ports.
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 1) == 1)
                a_drv(1'($urandom_range(0, 1)), int'($urandom_range(0, N0 - 1)),
                      ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255)));
            else if0.a_req = 1'b0;
            if ($urandom_range(0, 3) != 0)
                b_drv(2'($urandom_range(0, 3)), int'($urandom_range(0, N0 - 1)),
                      ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255)));
            else if0.b_valid = 1'b0;
            tick();
        end
        idle0(); repeat (4) tick();

        // Reset with adds in flight.
        repeat (3) begin b_drv(ADD, 4, 32'd1); tick(); end
        idle0();
        reset_n = 1'b0;
        since_rst = 0;
        #1;
        bq.delete(); aq.delete(); pend_vld = 1'b0;
        check_zero_outputs("midrst");
        repeat (2) tick();
        release_and_sweep("resweep");

        check("drain_b", bq.size(), 0);
        check("drain_a", aq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
